digi_unpack: RTL and testbench
==============================

DIGI_UNPACK -- requirements
Module: digi_unpack

Interface
REQ-001 SHALL have parameter WIDTH, default 12, FIFO word width.
REQ-002 SHALL have parameter SIZE, default 8, width of HOWMANY and of the sample counter.
REQ-003 SHALL have parameter BC_BITS, default 5, bunch-counter field width in the header word.
REQ-004 SHALL have port CLK  input  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port FIFO_DOUT  input  WIDTH  global FIFO q; valid the cycle after FIFO_RDREQ.
REQ-007 SHALL have port FIFO_EMPTY  input  1  global FIFO empty flag.
REQ-008 SHALL have port FIFO_RDREQ  output  1  pop request to the global FIFO.
REQ-009 SHALL have port HOWMANY  input  SIZE  samples per record; sampled only when a header is captured.
REQ-010 SHALL have port M_TDATA  output  16  {1'b0, chan[2:0], sample[11:0]}.
REQ-011 SHALL have port M_TUSER  output  BC_BITS  bunch counter of the record that owns the beat.
REQ-012 SHALL have port M_TVALID  output  1  beat valid.
REQ-013 SHALL have port M_TREADY  input  1  downstream accept.
REQ-014 SHALL have port M_TLAST  output  1  last sample of the record.
REQ-015 SHALL have port REC_COUNT  output  16  records fully emitted; wraps 0xFFFF->0.
REQ-016 SHALL have port HDR_ERR  output  1  sticky flag: header bits [WIDTH-1:8] were nonzero.
REQ-017 SHALL have port ZERO_LEN  output  1  sticky flag: a header arrived with HOWMANY==0.

Function
REQ-018 SHALL parse the input stream as records: one header word (bits[7:5]=chan, bits[4:0]=BC, upper bits 0), then HOWMANY sample words.
REQ-019 SHALL implement states IDLE, HDR and DATA.
REQ-020 IDLE: if FIFO_EMPTY==0, SHALL assert FIFO_RDREQ for one cycle and go to HDR.
REQ-021 HDR: SHALL capture chan, BC and HOWMANY from FIFO_DOUT and set HDR_ERR if FIFO_DOUT[WIDTH-1:8]!=0.
REQ-022 HDR: if HOWMANY==0, SHALL set ZERO_LEN, emit no beats, leave REC_COUNT unchanged and go to IDLE; otherwise SHALL go to DATA with fetch count = HOWMANY.
REQ-023 DATA: SHALL assert FIFO_RDREQ only when FIFO_EMPTY==0, fetch count>0, and (buffer occupancy + in-flight reads)<2.
REQ-024 SHALL never assert FIFO_RDREQ while FIFO_EMPTY==1.
REQ-025 SHALL decrement the fetch count per RDREQ and return to IDLE on the cycle the last fetch is issued.
REQ-026 The next header fetch MAY then overlap the drain of the buffer.
REQ-027 Each returned sample SHALL enter a 2-entry output buffer tagged with its own chan, BC and last flag.
REQ-028 Latency: RDREQ at cycle t -> FIFO_DOUT valid at t+1 -> M_TVALID at t+2 when the buffer is empty.
REQ-029 M_TDATA, M_TUSER and M_TLAST SHALL be held stable while M_TVALID=1 and M_TREADY=0.
REQ-030 A beat transfers when M_TVALID&M_TREADY; at most one beat per cycle.
REQ-031 SHALL sustain 1 beat/cycle with M_TREADY held high and the FIFO non-empty.
REQ-032 M_TLAST SHALL be 1 exactly on beat HOWMANY of each record.
REQ-033 REC_COUNT SHALL increment on each transfer with M_TLAST=1.
REQ-034 A push and a pop of the buffer in the same cycle SHALL leave the occupancy unchanged.
REQ-035 FIFO_EMPTY asserting mid-record SHALL stall fetching without loss and resume when it deasserts.

Reset
REQ-036 On RST=1: state=IDLE, buffer cleared, fetch count=0, in-flight read discarded.
REQ-037 On RST=1: FIFO_RDREQ=0, M_TVALID=0, M_TLAST=0, M_TDATA=0, M_TUSER=0, REC_COUNT=0, HDR_ERR=0, ZERO_LEN=0.
REQ-038 Reset mid-record SHALL abandon the record; parsing resumes treating the next popped word as a header.

Structure
REQ-039 SHALL put WIDTH, SIZE, BC_BITS, CHAN_BITS=3, the header field positions and the state encoding in the shared package digi_pkg.
REQ-040 SHALL implement the 2-entry tagged output buffer as sub-module skid_fifo2.

Verification
REQ-041 FIFO preloaded with {0x0A5, 0x101, 0x102, 0x103, 0x104}, HOWMANY=4, M_TREADY=1 -> 4 beats, M_TDATA=0x5101..0x5104, M_TUSER=0x05, M_TLAST on beat 4, REC_COUNT=1.
REQ-042 Same stream with M_TREADY toggling 1,0,0,1 -> no duplicate or lost beats, outputs held during stalls, at most 2 outstanding (buffer+in-flight).
REQ-043 Header 0x0E3 with HOWMANY=0, followed by header 0x020 and 2 samples with HOWMANY=2 -> ZERO_LEN=1, only the second record emitted (chan 1, TUSER 0x00), REC_COUNT=1.
REQ-044 Header 0x8A5 -> HDR_ERR=1 and stays 1; the record is still emitted.
REQ-045 RST pulsed after beat 2 of a 4-sample record, FIFO then holding header 0x0C0 and 1 sample, HOWMANY=1 -> all outputs 0 during reset, then a single beat with chan 6, M_TLAST=1, REC_COUNT=1.
REQ-046 FIFO_EMPTY forced 1 for 5 cycles mid-record -> FIFO_RDREQ=0 throughout, record completes intact afterwards.

Source files
------------

// File: rtl/digi_pkg.sv
// Shared definitions for the digitiser record unpacker: default widths,
// header field positions, FSM encoding and the output beat formatter.
package digi_pkg;

   localparam int DEF_WIDTH   = 12;
   localparam int DEF_SIZE    = 8;
   localparam int DEF_BC_BITS = 5;
   localparam int CHAN_BITS   = 3;
   localparam int SAMPLE_BITS = 12;
   localparam int TDATA_BITS  = 16;

   // Header word layout: [WIDTH-1:8] reserved (must be 0), [7:5] chan, [4:0] bunch counter
   localparam int HDR_BC_LSB   = 0;
   localparam int HDR_CHAN_LSB = 5;
   localparam int HDR_RSVD_LSB = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // Output beat: {1'b0, chan, sample}
   function automatic logic [TDATA_BITS-1:0] mk_tdata(input logic [CHAN_BITS-1:0]   chan,
                                                      input logic [SAMPLE_BITS-1:0] sample);
      return {1'b0, chan, sample};
   endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry output buffer. Entry 0 drives the outputs directly, so the beat
// only changes on a pop or on a push into an empty buffer. Drained entries
// are cleared so the outputs fall back to zero when the buffer is empty.
module skid_fifo2 #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic [1:0]    count
);

   logic [DW-1:0] ent0_q, ent0_d;
   logic [DW-1:0] ent1_q, ent1_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          pop;

   // Next-state of the two entries; a simultaneous push and pop keeps the count.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      pop    = (cnt_q != 2'd0) && pop_ready;
      unique case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) ent0_d = push_data;
            else               ent1_d = push_data;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            ent1_d = '0;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               ent0_d = push_data;
            end else begin
               ent0_d = ent1_q;
               ent1_d = push_data;
            end
         end
         default: ;
      endcase
   end

   // Entry and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_valid = (cnt_q != 2'd0);
   assign out_data  = ent0_q;
   assign count     = cnt_q;

endmodule

// File: rtl/digi_unpack.sv
// Unpacks header + sample records from the global FIFO into a tagged
// 16-bit beat stream with per-record last flag and bunch counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a header word; pops it as soon as FIFO non-empty
// ST_HDR  | header word on FIFO_DOUT; capture chan/BC/HOWMANY
// ST_DATA | fetching samples while buffer space and FIFO data allow
module digi_unpack
   import digi_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SIZE    = DEF_SIZE,
   parameter int BC_BITS = DEF_BC_BITS
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [WIDTH-1:0]      FIFO_DOUT,
   input  logic                  FIFO_EMPTY,
   output logic                  FIFO_RDREQ,
   input  logic [SIZE-1:0]       HOWMANY,
   output logic [TDATA_BITS-1:0] M_TDATA,
   output logic [BC_BITS-1:0]    M_TUSER,
   output logic                  M_TVALID,
   input  logic                  M_TREADY,
   output logic                  M_TLAST,
   output logic [15:0]           REC_COUNT,
   output logic                  HDR_ERR,
   output logic                  ZERO_LEN
);

   localparam int              BUF_W = 1 + BC_BITS + TDATA_BITS;
   localparam logic [SIZE-1:0] ONE   = 1;

   state_t                 state_q, state_d;
   logic [SIZE-1:0]        fetch_cnt_q, fetch_cnt_d;
   logic [CHAN_BITS-1:0]   chan_q, chan_d;
   logic [BC_BITS-1:0]     bc_q, bc_d;
   logic                   hdr_err_q, hdr_err_d;
   logic                   zero_len_q, zero_len_d;
   logic [15:0]            rec_count_q, rec_count_d;
   logic                   inflight_q, inflight_d;
   logic                   inflight_last_q, inflight_last_d;

   logic                   rd_req;
   logic                   pop;
   logic [2:0]             pending;
   logic [BUF_W-1:0]       push_data;
   logic                   buf_valid;
   logic [BUF_W-1:0]       buf_data;
   logic [1:0]             buf_cnt;
   logic                   buf_last;

   // A returning sample always belongs to the record whose tags are still in
   // chan_q/bc_q: the next header cannot be captured until two cycles after
   // the last sample fetch, by which time that sample has been pushed.
   assign push_data = {inflight_last_q, bc_q,
                       mk_tdata(chan_q, FIFO_DOUT[SAMPLE_BITS-1:0])};
   assign buf_last  = buf_data[BUF_W-1];

   // Sequencing, fetch gating and sticky status.
   always_comb begin
      state_d         = state_q;
      fetch_cnt_d     = fetch_cnt_q;
      chan_d          = chan_q;
      bc_d            = bc_q;
      hdr_err_d       = hdr_err_q;
      zero_len_d      = zero_len_q;
      rec_count_d     = rec_count_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      rd_req          = 1'b0;
      pop             = buf_valid & M_TREADY;
      // Occupancy is taken net of this cycle's pop so a full-rate stream
      // keeps exactly one sample buffered and one in flight.
      pending         = {1'b0, buf_cnt} - {2'b00, pop} + {2'b00, inflight_q};

      unique case (state_q)
         ST_IDLE: begin
            if (!FIFO_EMPTY) begin
               rd_req  = 1'b1;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            chan_d = FIFO_DOUT[HDR_CHAN_LSB +: CHAN_BITS];
            bc_d   = FIFO_DOUT[HDR_BC_LSB +: BC_BITS];
            if (FIFO_DOUT[WIDTH-1:HDR_RSVD_LSB] != '0) hdr_err_d = 1'b1;
            if (HOWMANY == '0) begin
               zero_len_d = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               fetch_cnt_d = HOWMANY;
               state_d     = ST_DATA;
            end
         end
         ST_DATA: begin
            if (!FIFO_EMPTY && (fetch_cnt_q != '0) && (pending < 3'd2)) begin
               rd_req          = 1'b1;
               inflight_d      = 1'b1;
               inflight_last_d = (fetch_cnt_q == ONE);
               fetch_cnt_d     = fetch_cnt_q - ONE;
               if (fetch_cnt_q == ONE) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop && buf_last) rec_count_d = rec_count_q + 16'd1;
   end

   // FSM and record-tracking registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q         <= ST_IDLE;
         fetch_cnt_q     <= '0;
         chan_q          <= '0;
         bc_q            <= '0;
         hdr_err_q       <= 1'b0;
         zero_len_q      <= 1'b0;
         rec_count_q     <= 16'd0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         fetch_cnt_q     <= fetch_cnt_d;
         chan_q          <= chan_d;
         bc_q            <= bc_d;
         hdr_err_q       <= hdr_err_d;
         zero_len_q      <= zero_len_d;
         rec_count_q     <= rec_count_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

   skid_fifo2 #(
      .DW(BUF_W)
   ) u_buf (
      .clk       (CLK),
      .rst       (RST),
      .push      (inflight_q),
      .push_data (push_data),
      .pop_ready (M_TREADY),
      .out_valid (buf_valid),
      .out_data  (buf_data),
      .count     (buf_cnt)
   );

   // The pop request is combinational so it can never outrun FIFO_EMPTY;
   // it is held off while reset is applied.
   assign FIFO_RDREQ = rd_req & ~RST;
   assign M_TVALID   = buf_valid;
   assign M_TDATA    = buf_data[TDATA_BITS-1:0];
   assign M_TUSER    = buf_data[TDATA_BITS +: BC_BITS];
   assign M_TLAST    = buf_last;
   assign REC_COUNT  = rec_count_q;
   assign HDR_ERR    = hdr_err_q;
   assign ZERO_LEN   = zero_len_q;

endmodule

// File: tb/tb_digi_unpack.sv
// Directed bench for digi_unpack: behavioural show-ahead-free FIFO model,
// beat logger, and hand-computed expected beats per scenario.
module tb_digi_unpack;

   localparam int WIDTH   = 12;
   localparam int SIZE    = 8;
   localparam int BC_BITS = 5;

   logic               CLK        = 1'b0;
   logic               RST        = 1'b1;
   logic [WIDTH-1:0]   FIFO_DOUT  = '0;
   logic               FIFO_EMPTY;
   logic               FIFO_RDREQ;
   logic [SIZE-1:0]    HOWMANY    = 8'd4;
   logic [15:0]        M_TDATA;
   logic [BC_BITS-1:0] M_TUSER;
   logic               M_TVALID;
   logic               M_TREADY   = 1'b1;
   logic               M_TLAST;
   logic [15:0]        REC_COUNT;
   logic               HDR_ERR;
   logic               ZERO_LEN;

   digi_unpack #(
      .WIDTH   (WIDTH),
      .SIZE    (SIZE),
      .BC_BITS (BC_BITS)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .FIFO_DOUT  (FIFO_DOUT),
      .FIFO_EMPTY (FIFO_EMPTY),
      .FIFO_RDREQ (FIFO_RDREQ),
      .HOWMANY    (HOWMANY),
      .M_TDATA    (M_TDATA),
      .M_TUSER    (M_TUSER),
      .M_TVALID   (M_TVALID),
      .M_TREADY   (M_TREADY),
      .M_TLAST    (M_TLAST),
      .REC_COUNT  (REC_COUNT),
      .HDR_ERR    (HDR_ERR),
      .ZERO_LEN   (ZERO_LEN)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- global FIFO model (data valid the cycle after RDREQ)
   logic [WIDTH-1:0] mem [256];
   int               rd_ptr      = 0;
   int               wr_ptr      = 0;
   logic             force_empty = 1'b0;

   assign FIFO_EMPTY = force_empty || (rd_ptr == wr_ptr);

   always @(posedge CLK) begin
      if (FIFO_RDREQ && !FIFO_EMPTY) begin
         FIFO_DOUT <= mem[rd_ptr & 255];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic push_word(input logic [WIDTH-1:0] w);
      mem[wr_ptr & 255] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   // ---------------- beat logger and protocol monitor (samples at negedge)
   int          cyc        = 0;
   int          beat_n     = 0;
   int          stab_viol  = 0;
   int          rd_viol    = 0;
   logic [15:0] b_data [64];
   logic [4:0]  b_user [64];
   logic        b_last [64];
   int          b_cyc  [64];
   logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [15:0] pd = '0;
   logic [4:0]  pu = '0;

   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (FIFO_RDREQ && FIFO_EMPTY) rd_viol = rd_viol + 1;
      if (!RST && pv && !pr &&
          (!M_TVALID || M_TDATA != pd || M_TUSER != pu || M_TLAST != pl))
         stab_viol = stab_viol + 1;
      if (M_TVALID && M_TREADY) begin
         b_data[beat_n & 63] = M_TDATA;
         b_user[beat_n & 63] = M_TUSER;
         b_last[beat_n & 63] = M_TLAST;
         b_cyc[beat_n & 63]  = cyc;
         beat_n = beat_n + 1;
      end
      pv = M_TVALID && !RST;
      pr = M_TREADY;
      pd = M_TDATA;
      pu = M_TUSER;
      pl = M_TLAST;
   end

   // ---------------- stimulus helpers
   int base;

   task automatic do_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   // Run until n beats since base (or budget expires), driving TREADY from pat.
   task automatic run_until(input int n, input int budget, input logic [3:0] pat);
      for (int i = 0; i < budget; i++) begin
         @(posedge CLK);
         #1;
         M_TREADY = pat[i % 4];
         if (beat_n - base >= n) break;
      end
      M_TREADY = 1'b1;
      repeat (6) @(posedge CLK);
      #1;
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [15:0] d,
                           input logic [4:0] u, input logic l);
      chk($sformatf("%s[%0d] tdata", tag, idx), b_data[(base + idx) & 63], d);
      chk($sformatf("%s[%0d] tuser", tag, idx), b_user[(base + idx) & 63], u);
      chk($sformatf("%s[%0d] tlast", tag, idx), b_last[(base + idx) & 63], l);
   endtask

   int stab0;

   initial begin
      do_reset();
      chk("post-reset tvalid", M_TVALID, 0);
      chk("post-reset rec_count", REC_COUNT, 0);

      // T1: basic record at full rate
      base = beat_n;
      HOWMANY = 8'd4;
      push_word(12'h0A5);
      for (int k = 1; k <= 4; k++) push_word(12'h100 + k);
      run_until(4, 40, 4'b1111);
      chk("t1 beats", beat_n - base, 4);
      for (int k = 0; k < 4; k++) chk_beat("t1", k, 16'h5101 + k, 5'h05, k == 3);
      chk("t1 back-to-back", b_cyc[(base + 3) & 63] - b_cyc[base & 63], 3);
      chk("t1 rec_count", REC_COUNT, 1);

      // T2: same stream with TREADY 1,0,0,1
      do_reset();
      base  = beat_n;
      stab0 = stab_viol;
      push_word(12'h0A5);
      for (int k = 1; k <= 4; k++) push_word(12'h100 + k);
      run_until(4, 60, 4'b1001);
      chk("t2 beats", beat_n - base, 4);
      for (int k = 0; k < 4; k++) chk_beat("t2", k, 16'h5101 + k, 5'h05, k == 3);
      chk("t2 hold during stall", stab_viol - stab0, 0);
      chk("t2 rec_count", REC_COUNT, 1);

      // T3: zero-length header then a 2-sample record
      do_reset();
      base    = beat_n;
      HOWMANY = 8'd0;
      push_word(12'h0E3);
      push_word(12'h020);
      push_word(12'h7AA);
      push_word(12'h055);
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK);
         #1;
         if (ZERO_LEN) break;
      end
      HOWMANY = 8'd2;
      run_until(2, 40, 4'b1111);
      chk("t3 zero_len", ZERO_LEN, 1);
      chk("t3 beats", beat_n - base, 2);
      chk_beat("t3", 0, 16'h17AA, 5'h00, 1'b0);
      chk_beat("t3", 1, 16'h1055, 5'h00, 1'b1);
      chk("t3 rec_count", REC_COUNT, 1);
      chk("t3 hdr_err", HDR_ERR, 0);

      // T4: reserved header bits set; flag is sticky across the next record
      do_reset();
      base    = beat_n;
      HOWMANY = 8'd1;
      push_word(12'h8A5);
      push_word(12'h333);
      run_until(1, 30, 4'b1111);
      chk("t4 hdr_err set", HDR_ERR, 1);
      chk_beat("t4", 0, 16'h5333, 5'h05, 1'b1);
      push_word(12'h0A5);
      push_word(12'h444);
      run_until(2, 30, 4'b1111);
      chk("t4 hdr_err sticky", HDR_ERR, 1);
      chk_beat("t4", 1, 16'h5444, 5'h05, 1'b1);
      chk("t4 rec_count", REC_COUNT, 2);
      chk("t4 zero_len", ZERO_LEN, 0);

      // T5: reset after beat 2 of a 4-sample record
      do_reset();
      base    = beat_n;
      HOWMANY = 8'd4;
      push_word(12'h0A5);
      for (int k = 1; k <= 4; k++) push_word(12'h200 + k);
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         #1;
         if (beat_n - base >= 2) break;
      end
      chk("t5 beats before reset", beat_n - base, 2);
      RST = 1'b1;
      @(negedge CLK);
      #1;
      chk("t5 rst rdreq", FIFO_RDREQ, 0);
      chk("t5 rst tvalid", M_TVALID, 0);
      chk("t5 rst tlast", M_TLAST, 0);
      chk("t5 rst tdata", M_TDATA, 0);
      chk("t5 rst tuser", M_TUSER, 0);
      chk("t5 rst rec_count", REC_COUNT, 0);
      chk("t5 rst hdr_err", HDR_ERR, 0);
      chk("t5 rst zero_len", ZERO_LEN, 0);
      wr_ptr = rd_ptr;
      push_word(12'h0C0);
      push_word(12'h999);
      HOWMANY = 8'd1;
      @(posedge CLK);
      #1;
      RST  = 1'b0;
      base = beat_n;
      run_until(1, 30, 4'b1111);
      chk("t5 beats after reset", beat_n - base, 1);
      chk_beat("t5", 0, 16'h6999, 5'h00, 1'b1);
      chk("t5 rec_count", REC_COUNT, 1);

      // T6: FIFO empty for 5 cycles mid-record
      do_reset();
      base    = beat_n;
      HOWMANY = 8'd4;
      push_word(12'h0A5);
      for (int k = 1; k <= 4; k++) push_word(12'h010 + k);
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK);
         #1;
         if (beat_n - base >= 1) break;
      end
      force_empty = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         #1;
         chk($sformatf("t6 rdreq stalled c%0d", i), FIFO_RDREQ, 0);
      end
      force_empty = 1'b0;
      run_until(4, 40, 4'b1111);
      chk("t6 beats", beat_n - base, 4);
      for (int k = 0; k < 4; k++) chk_beat("t6", k, 16'h5011 + k, 5'h05, k == 3);
      chk("t6 rec_count", REC_COUNT, 1);

      chk("rdreq while empty", rd_viol, 0);
      chk("output hold violations", stab_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
